// File: rtl/display_pkg.sv
// display_pkg: shared constants and types for the 7-segment scan controller.
//   NDIG_DEFAULT  default digit count
//   SEG_OFF       segment bus with every segment and the dp dark
//   SEG_DP_ONLY   segment bus with only the dp lit
//   DIG_OFF_BIT   level of an inactive digit enable (enables are active low)
//   SEG_TABLE     hex nibble -> {a,b,c,d,e,f,g,dp}, active low, dp dark
//   phase_t       position of the scan counter within a digit slot
package display_pkg;

    localparam int unsigned NDIG_DEFAULT = 8;

    localparam logic [7:0] SEG_OFF     = 8'hFF;
    localparam logic [7:0] SEG_DP_ONLY = 8'hFE;
    localparam logic       DIG_OFF_BIT = 1'b1;

    localparam logic [7:0] SEG_TABLE [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D,   // 0 1 2 3
        8'h99, 8'h49, 8'h41, 8'h1F,   // 4 5 6 7
        8'h01, 8'h09, 8'h11, 8'hC1,   // 8 9 A b
        8'h63, 8'h85, 8'h61, 8'h71    // C d E F
    };

    typedef enum logic [1:0] {
        PH_BLANK,
        PH_ON,
        PH_OFF
    } phase_t;

endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational hex nibble to 7-segment decoder.
//   nib  in   4  hex value
//   seg  out  7  {a,b,c,d,e,f,g}, active low
module hex_to_seg
    import display_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TABLE[nib][7:1];
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed 7-segment display scan scheduler.
// Scans NDIG digits right to left, one slot of TICK_DIV cycles each. Every
// slot opens with a BLANK_CYC dark gap, then lights the digit for
// (brightness+1)*STEP cycles, then stays dark for the rest of the slot.
// All display inputs are sampled once per frame so a frame never tears.
//   clk5        in   1       scan clock
//   rstn        in   1       asynchronous active-low reset
//   enable      in   1       1 = scan runs, 0 = dark and held at frame start
//   dispVal     in   4*NDIG  hex nibbles, [3:0] is digit 0 (rightmost)
//   dpMask      in   NDIG    decimal point per digit
//   brightness  in   4       on-time quantum count minus one
//   lzSuppress  in   1       blank leading zero digits
//   digit       out  NDIG    digit enables, active low
//   segment     out  8       {a,b,c,d,e,f,g,dp}, active low
//   frameStart  out  1       high in the cycle the frame is captured
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned NDIG      = NDIG_DEFAULT,
    parameter int unsigned TICK_DIV  = 5000,
    parameter int unsigned BLANK_CYC = 250
) (
    input  logic              clk5,
    input  logic              rstn,
    input  logic              enable,
    input  logic [4*NDIG-1:0] dispVal,
    input  logic [NDIG-1:0]   dpMask,
    input  logic [3:0]        brightness,
    input  logic              lzSuppress,
    output logic [NDIG-1:0]   digit,
    output logic [7:0]        segment,
    output logic              frameStart
);

    localparam int unsigned STEP = (TICK_DIV - BLANK_CYC) / 16;
    localparam int unsigned CW   = $clog2(TICK_DIV);
    localparam int unsigned IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic              capture;

    logic [4*NDIG-1:0] sh_val;
    logic [NDIG-1:0]   sh_dp;
    logic [3:0]        sh_bright;
    logic              sh_lz;

    logic [NDIG-1:0]   lz_mask;
    logic [NDIG-1:0]   lz_mask_d;
    logic              zero_run;

    logic [3:0]        nib;
    logic              dp_bit;
    logic              lz_bit;
    logic [6:0]        seg7;
    logic [CW:0]       on_end;
    phase_t            phase;

    logic [NDIG-1:0]   digit_d;
    logic [7:0]        segment_d;

    assign capture = enable && (cnt == '0) && (idx == '0);

    // Counters rest at frame start during reset, so the pulse is also gated
    // by rstn to keep it low while reset is held.
    assign frameStart = rstn && capture;

    // Prescaler and digit index.
    always_ff @(posedge clk5 or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
            idx <= '0;
        end else if (!enable) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CW'(TICK_DIV - 1)) begin
            cnt <= '0;
            idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Per-frame shadow copy of every display input.
    always_ff @(posedge clk5 or negedge rstn) begin
        if (!rstn) begin
            sh_val    <= '0;
            sh_dp     <= '0;
            sh_bright <= '0;
            sh_lz     <= 1'b0;
        end else if (capture) begin
            sh_val    <= dispVal;
            sh_dp     <= dpMask;
            sh_bright <= brightness;
            sh_lz     <= lzSuppress;
        end
    end

    // Digit i is a leading zero when nibbles NDIG-1 down to i are all zero.
    // Digit 0 is never flagged. The registered mask settles within the
    // blanking gap of slot 0, before any digit is lit.
    always_comb begin
        lz_mask_d = '0;
        zero_run  = 1'b1;
        for (int unsigned i = NDIG - 1; i >= 1; i--) begin
            zero_run     = zero_run && (sh_val[4*i +: 4] == 4'h0);
            lz_mask_d[i] = zero_run;
        end
    end

    always_ff @(posedge clk5 or negedge rstn) begin
        if (!rstn) begin
            lz_mask <= '0;
        end else begin
            lz_mask <= lz_mask_d;
        end
    end

    // Select the shadow data for the digit currently being scanned.
    always_comb begin
        nib    = '0;
        dp_bit = 1'b0;
        lz_bit = 1'b0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (idx == IW'(i)) begin
                nib    = sh_val[4*i +: 4];
                dp_bit = sh_dp[i];
                lz_bit = lz_mask[i];
            end
        end
    end

    hex_to_seg u_hex_to_seg (
        .nib (nib),
        .seg (seg7)
    );

    always_comb begin
        on_end = (CW+1)'(BLANK_CYC + (32'(sh_bright) + 32'd1) * STEP);
        if (cnt < CW'(BLANK_CYC)) begin
            phase = PH_BLANK;
        end else if ({1'b0, cnt} < on_end) begin
            phase = PH_ON;
        end else begin
            phase = PH_OFF;
        end
    end

    // A suppressed digit still shows its dp when requested; otherwise it
    // stays fully dark, enable included.
    always_comb begin
        digit_d   = {NDIG{DIG_OFF_BIT}};
        segment_d = SEG_OFF;
        if (enable && (phase == PH_ON)) begin
            if (!(sh_lz && lz_bit)) begin
                digit_d[idx] = ~DIG_OFF_BIT;
                segment_d    = {seg7, ~dp_bit};
            end else if (dp_bit) begin
                digit_d[idx] = ~DIG_OFF_BIT;
                segment_d    = SEG_DP_ONLY;
            end
        end
    end

    always_ff @(posedge clk5 or negedge rstn) begin
        if (!rstn) begin
            digit   <= {NDIG{DIG_OFF_BIT}};
            segment <= SEG_OFF;
        end else begin
            digit   <= digit_d;
            segment <= segment_d;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard bench for display_scan_ctrl.
// At each frame start the stimulus predicts every lit window of the frame
// (start cycle, length, digit enable, segment pattern) and the frameStart
// cycle, and queues them; an independent monitor observes the outputs every
// cycle and compares each observed window and pulse with the queue.
module tb_display_scan_ctrl;

    localparam int T     = 40;
    localparam int B     = 8;
    localparam int STEP  = (T - B) / 16;
    localparam int ND    = 8;
    localparam int FRAME = ND * T;

    // Lit segments per hex value, active high, {a,b,c,d,e,f,g}.
    localparam logic [6:0] LIT [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    typedef struct {
        int         start;
        int         len;
        logic [7:0] dig;
        logic [7:0] seg;
    } win_t;

    logic        clk5;
    logic        rstn;
    logic        enable;
    logic [31:0] dispVal;
    logic [7:0]  dpMask;
    logic [3:0]  brightness;
    logic        lzSuppress;
    logic [7:0]  digit;
    logic [7:0]  segment;
    logic        frameStart;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    win_t win_q[$];
    int   fs_q[$];
    bit   discard  = 1'b0;

    display_scan_ctrl #(
        .NDIG      (ND),
        .TICK_DIV  (T),
        .BLANK_CYC (B)
    ) dut (
        .clk5       (clk5),
        .rstn       (rstn),
        .enable     (enable),
        .dispVal    (dispVal),
        .dpMask     (dpMask),
        .brightness (brightness),
        .lzSuppress (lzSuppress),
        .digit      (digit),
        .segment    (segment),
        .frameStart (frameStart)
    );

    initial clk5 = 1'b0;
    always #5 clk5 = ~clk5;
    always @(posedge clk5) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: windows a frame captured in cycle f must produce.
    function automatic void push_frame(input int f, input logic [31:0] v, input logic [7:0] dp,
                                       input logic [3:0] br, input logic lz);
        int         hi;
        bit         blank;
        logic [3:0] n;
        win_t       w;
        hi = -1;
        for (int i = 0; i < ND; i++)
            if (((v >> (4 * i)) & 32'hF) != 0) hi = i;
        fs_q.push_back(f);
        for (int s = 0; s < ND; s++) begin
            n     = 4'((v >> (4 * s)) & 32'hF);
            blank = lz && (s > hi) && (s != 0);
            if (!blank || dp[s]) begin
                w.start = f + 1 + s * T + B;
                w.len   = (int'(br) + 1) * STEP;
                w.dig   = ~(8'h01 << s);
                w.seg   = blank ? 8'hFE : {~LIT[n], ~dp[s]};
                win_q.push_back(w);
            end
        end
    endfunction

    // Monitor.
    initial begin
        bit   in_win;
        bit   cur_ok;
        int   w_start;
        win_t cur;
        in_win = 1'b0;
        cur_ok = 1'b0;
        w_start = 0;
        forever begin
            @(negedge clk5);
            check("digit_onehot_low", ($countones(~digit) <= 1) ? 1 : 0, 1);
            if (frameStart) begin
                if (fs_q.size() == 0) check("frame_start_spurious", frameStart, 0);
                else check("frame_start_cycle", cyc, fs_q.pop_front());
            end
            if (digit != 8'hFF) begin
                if (!in_win) begin
                    in_win  = 1'b1;
                    w_start = cyc;
                    if (win_q.size() == 0) begin
                        cur_ok = 1'b0;
                        check("win_spurious", digit, 8'hFF);
                    end else begin
                        cur    = win_q.pop_front();
                        cur_ok = 1'b1;
                        check("win_start", cyc, cur.start);
                    end
                end
                if (cur_ok) begin
                    check("win_digit", digit, cur.dig);
                    check("win_segment", segment, cur.seg);
                end
            end else begin
                check("dark_segment", segment, 8'hFF);
                if (in_win) begin
                    in_win = 1'b0;
                    if (discard) discard = 1'b0;
                    else if (cur_ok) check("win_length", cyc - w_start, cur.len);
                end else if (discard) begin
                    discard = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk5);
        #1;
    endtask

    // Abort the running frame by dropping enable or by pulsing reset.
    task automatic stop_now(input bit use_rst, input logic [7:0] live_dig);
        check("stop_live_digit", digit, live_dig);
        win_q.delete();
        fs_q.delete();
        discard = 1'b1;
        if (!use_rst) begin
            enable = 1'b0;
            @(negedge clk5);
            check("stop_still_live", digit, live_dig);
            @(negedge clk5);
            check("stop_dark_digit", digit, 8'hFF);
            check("stop_dark_segment", segment, 8'hFF);
            check("stop_no_frame_start", frameStart, 0);
        end else begin
            #2;
            rstn = 1'b0;
            #1;
            check("rst_async_digit", digit, 8'hFF);
            check("rst_async_segment", segment, 8'hFF);
            check("rst_async_frame_start", frameStart, 0);
        end
    endtask

    // Runs one frame whose capture happens in the current cycle.
    task automatic frame(input logic [31:0] v, input logic [7:0] dp, input logic [3:0] br,
                         input logic lz, input int mid_t, input int abort_t,
                         input bit use_rst, input logic [7:0] live_dig);
        dispVal    = v;
        dpMask     = dp;
        brightness = br;
        lzSuppress = lz;
        enable     = 1'b1;
        push_frame(cyc, v, dp, br, lz);
        for (int t = 1; t <= FRAME; t++) begin
            step();
            if (t == mid_t) begin
                dispVal    = $urandom;
                dpMask     = 8'($urandom);
                brightness = 4'($urandom);
                lzSuppress = 1'($urandom);
            end
            if (t == abort_t) begin
                stop_now(use_rst, live_dig);
                return;
            end
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [7:0]  dp;
        logic [3:0]  br;
        logic        lz;

        rstn       = 1'b0;
        enable     = 1'b0;
        dispVal    = '0;
        dpMask     = '0;
        brightness = 4'd15;
        lzSuppress = 1'b0;
        step();
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk5);
            check("reset_digit", digit, 8'hFF);
            check("reset_segment", segment, 8'hFF);
            check("reset_frame_start", frameStart, 0);
            step();
        end
        rstn = 1'b1;

        // Scan order, then wrap into a second frame.
        frame(32'h0123_45A5, 8'h00, 4'd15, 1'b0, -1, -1, 1'b0, 8'hFF);
        frame(32'h0123_45A5, 8'h00, 4'd15, 1'b0, -1, -1, 1'b0, 8'hFF);
        // Leading-zero suppression.
        frame(32'h0000_00A5, 8'h00, 4'd15, 1'b1, -1, -1, 1'b0, 8'hFF);
        frame(32'h0000_0000, 8'h00, 4'd15, 1'b1, -1, -1, 1'b0, 8'hFF);
        frame(32'h0000_0000, 8'h04, 4'd15, 1'b1, -1, -1, 1'b0, 8'hFF);
        // Brightness extremes and a mid-frame brightness change.
        frame(32'h9876_5432, 8'h10, 4'd0,  1'b0, -1, -1, 1'b0, 8'hFF);
        frame(32'h0000_FEDC, 8'h02, 4'd7,  1'b1, 2 * T + 3, -1, 1'b0, 8'hFF);
        // Tear-free capture: inputs change during slot 3.
        frame(32'h89AB_CDEF, 8'h81, 4'd15, 1'b0, 3 * T + 10, -1, 1'b0, 8'hFF);
        // Enable dropped mid-ON in slot 5, then restart.
        frame(32'h1234_5678, 8'h00, 4'd15, 1'b0, -1, 5 * T + B + 4, 1'b0, 8'hDF);
        repeat (6) step();
        frame(32'h0000_0B07, 8'h40, 4'd9,  1'b1, -1, -1, 1'b0, 8'hFF);
        // Reset pulse mid-ON in slot 2, held with enable high, then release.
        frame(32'hCAFE_F00D, 8'h00, 4'd15, 1'b0, -1, 2 * T + B + 10, 1'b1, 8'hFB);
        repeat (3) step();
        rstn = 1'b1;
        frame(32'h0000_0300, 8'h01, 4'd3,  1'b1, -1, -1, 1'b0, 8'hFF);

        // Randomized frames with random mid-frame input changes.
        for (int k = 0; k < 10; k++) begin
            v  = $urandom >> (4 * $urandom_range(0, 8));
            dp = 8'($urandom) & 8'($urandom);
            br = 4'($urandom);
            lz = 1'($urandom);
            frame(v, dp, br, lz, $urandom_range(FRAME - 1, 1), -1, 1'b0, 8'hFF);
        end

        enable = 1'b0;
        repeat (5) step();
        check("windows_all_seen", win_q.size(), 0);
        check("frame_starts_all_seen", fs_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
